uart_tx_7n: RTL



---
 rtl/uart_tx_7n.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_7n.sv
// rtl/uart_tx_7n.sv - 7N1 UART transmitter with integer baud divider
//
// Accepts a 7-bit character on a valid/ready handshake. Sends it as one start
// bit, 7 data bits LSB first and one stop bit. Each bit lasts DIV clock cycles.
//
// Ports:
//   clk       system clock (oscillator output)
//   rst       asynchronous, active-high reset
//   tx_data   character to send, bit 0 goes out first
//   tx_valid  tx_data holds a character to send
//   tx_ready  block can accept a character this cycle (high only when idle)
//   tx        serial line, idle high
//   busy      frame in progress
module uart_tx_7n #(
  parameter int CLK_HZ = 125_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  // Rounded cycles per bit.
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_7n: CLK_HZ/BAUD gives fewer than 2 cycles per bit");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [6:0]    shreg, shreg_n;
  logic          tx_n, tx_ready_n, busy_n;
  logic          accept, bit_end;

  assign accept  = tx_valid && tx_ready;
  assign bit_end = (baud_cnt == BAUD_LAST);

  // State and output registers. Outputs are registered from the next-state
  // values, so tx changes in the same edge that accepts or advances a bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      tx_ready <= tx_ready_n;
      busy     <= busy_n;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n    = START;
          baud_cnt_n = '0;
          shreg_n    = tx_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_n    = DATA;
          baud_cnt_n = '0;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b0, shreg[6:1]};
          if (bit_cnt == 3'd6) begin
            bit_cnt_n = '0;
            state_n   = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n    = IDLE;
          baud_cnt_n = '0;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output values for the coming state. In DATA the line carries bit 0 of the
  // already shifted register, so a shift and its new bit land on one edge.
  always_comb begin
    tx_n       = 1'b1;
    tx_ready_n = 1'b0;
    busy_n     = 1'b1;
    case (state_n)
      IDLE: begin
        tx_ready_n = 1'b1;
        busy_n     = 1'b0;
      end
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

endmodule
